// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end; PC, word-addressed imem requests, in-order queue to decode.
// Ports:
//   clk, rst (async, active-low)
//   imem_req/imem_addr/imem_gnt      request side, imem_addr is the current PC
//   imem_rvalid/imem_rdata           in-order responses, at least one cycle after gnt
//   inst_valid/inst/inst_pc/inst_ready  head of the instruction queue to decode
//   redirect/redirect_pc             flush the queue, drop outstanding responses, refetch from redirect_pc
module fetch_stage #(
    parameter int WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [WIDTH-1:0]      imem_rdata,
    output logic                  inst_valid,
    output logic [WIDTH-1:0]      inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] pc, resp_pc;
    logic [WIDTH-1:0]      q_inst [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count, inflight, drop;
    logic [CW:0]           used;
    logic                  fire, push, pop;

    // Credit: queued plus in-flight fetches never exceed the queue size, so a push always has room.
    assign used       = {1'b0, count} + {1'b0, inflight};
    assign imem_req   = rst && !redirect && (used < (CW+1)'(DEPTH));
    assign imem_addr  = pc;
    assign fire       = imem_req && imem_gnt;
    assign push       = imem_rvalid && (drop == '0) && !redirect;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign inst_valid = (count != '0);
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            inflight <= inflight + CW'(fire) - CW'(imem_rvalid);
            if (redirect) begin
                pc      <= redirect_pc;
                resp_pc <= redirect_pc;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                // Every response still owed after this edge belongs to the old stream.
                drop    <= inflight - CW'(imem_rvalid);
            end else begin
                if (fire)
                    pc <= pc + ADDR_WIDTH'(1);
                if (imem_rvalid && drop != '0)
                    drop <= drop - CW'(1);
                if (push) begin
                    q_inst[wr_ptr] <= imem_rdata;
                    q_pc[wr_ptr]   <= resp_pc;
                    wr_ptr         <= wr_ptr + PW'(1);
                    resp_pc        <= resp_pc + ADDR_WIDTH'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage with an in-order memory model and an expected-stream scoreboard.
module tb_fetch_stage;
    logic        clk = 0;
    logic        rst = 0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 0;
    logic        imem_rvalid = 0;
    logic [15:0] imem_rdata = 0;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready = 0;
    logic        redirect = 0;
    logic [15:0] redirect_pc = 0;

    int pass_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;
    int lat = 1;
    bit gnt_on = 1;
    bit gnt_rand = 0;
    logic [15:0] exp_pc = 16'h0;

    typedef struct {
        logic [15:0] a;
        int          due;
    } req_t;
    req_t pend[$];

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory: fixed latency, in order, data = addr ^ A5A5. Scoreboard: every accepted instruction
    // must be the next PC of the current stream, which restarts at each redirect and at reset.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            pend.delete();
            imem_gnt = 0;
            imem_rvalid = 0;
        end else begin
            imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_on;
            imem_rvalid = 0;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1;
                imem_rdata = pend[0].a ^ 16'hA5A5;
                void'(pend.pop_front());
            end
        end
        #2;
        if (rst) begin
            if (imem_req && imem_gnt)
                pend.push_back('{imem_addr, cyc + lat});
            if (redirect) begin
                chk_cnt++;
                if (imem_req !== 1'b0) $display("FAIL sb_req_in_redirect got %b want 0", imem_req);
                else pass_cnt++;
                exp_pc = redirect_pc;
            end else if (inst_valid && inst_ready) begin
                chk_cnt++;
                if (inst_pc !== exp_pc || inst !== (exp_pc ^ 16'hA5A5))
                    $display("FAIL sb_stream got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst, exp_pc, exp_pc ^ 16'hA5A5);
                else pass_cnt++;
                exp_pc = exp_pc + 16'h1;
            end
        end else
            exp_pc = 16'h0;
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task restart();
        @(negedge clk);
        rst = 0;
        redirect = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task test_reset();
        rst = 0;
        inst_ready = 1;
        repeat (2) @(negedge clk);
        #4;
        chk_cnt++;
        if ({imem_req, imem_addr, inst_valid, inst, inst_pc} !== {1'b0, 16'h0, 1'b0, 16'h0, 16'h0})
            $display("FAIL reset_outputs got req=%b addr=%h v=%b inst=%h pc=%h want 0 0 0 0 0",
                     imem_req, imem_addr, inst_valid, inst, inst_pc);
        else pass_cnt++;
    endtask

    task test_free_run();
        lat = 1; gnt_rand = 0; gnt_on = 1; inst_ready = 1;
        restart();
        #4;
        chk_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0}) $display("FAIL fr_first_req got %b/%h want 1/0000", imem_req, imem_addr);
        else pass_cnt++;
        @(negedge clk); #4;
        chk_cnt++;
        if (inst_valid !== 1'b0) $display("FAIL fr_latency got valid=%b want 0", inst_valid);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #4;
            chk_cnt++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, 16'(i), 16'(i) ^ 16'hA5A5})
                $display("FAIL fr_stream got v=%b pc=%h inst=%h want 1 %h %h", inst_valid, inst_pc, inst, 16'(i), 16'(i) ^ 16'hA5A5);
            else pass_cnt++;
        end
    endtask

    task test_stall();
        int n;
        lat = 1; gnt_rand = 0; gnt_on = 1; inst_ready = 0;
        restart();
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (k != 0) @(negedge clk);
            #4;
            n += int'(imem_req);
        end
        chk_cnt++;
        if (n != 4) $display("FAIL stall_req_count got %0d want 4", n);
        else pass_cnt++;
        chk_cnt++;
        if ({inst_valid, inst_pc} !== {1'b1, 16'h0}) $display("FAIL stall_head got v=%b pc=%h want 1 0000", inst_valid, inst_pc);
        else pass_cnt++;
        @(negedge clk);
        inst_ready = 1;
        for (int k = 0; k < 8; k++) begin
            #4;
            chk_cnt++;
            if ({inst_valid, inst_pc} !== {1'b1, 16'(k)}) $display("FAIL stall_drain got v=%b pc=%h want 1 %h", inst_valid, inst_pc, 16'(k));
            else pass_cnt++;
            if (k == 0) begin
                chk_cnt++;
                if (imem_req !== 1'b0) $display("FAIL stall_full_req got %b want 0", imem_req);
                else pass_cnt++;
            end
            if (k == 1) begin
                chk_cnt++;
                if ({imem_req, imem_addr} !== {1'b1, 16'h4}) $display("FAIL stall_resume got %b/%h want 1/0004", imem_req, imem_addr);
                else pass_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task test_redirect_inflight();
        bit found;
        lat = 3; gnt_rand = 0; gnt_on = 0; inst_ready = 1;
        restart();
        @(negedge clk); gnt_on = 1;
        @(negedge clk);
        @(negedge clk); redirect = 1; redirect_pc = 16'h0040;
        #4;
        chk_cnt++;
        if (imem_req !== 1'b0) $display("FAIL ri_req_in_R got %b want 0", imem_req);
        else pass_cnt++;
        @(negedge clk); redirect = 0;
        #4;
        chk_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0040}) $display("FAIL ri_restart got %b/%h want 1/0040", imem_req, imem_addr);
        else pass_cnt++;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk); #4;
            found = inst_valid;
        end
        chk_cnt++;
        if (!found || inst_pc !== 16'h0040 || inst !== (16'h0040 ^ 16'hA5A5))
            $display("FAIL ri_first_valid got found=%b pc=%h inst=%h want 1 0040 %h", found, inst_pc, inst, 16'h0040 ^ 16'hA5A5);
        else pass_cnt++;
        repeat (4) @(negedge clk);
    endtask

    task test_redirect_restart(input logic [15:0] target, input int n);
        lat = 1; gnt_rand = 0; gnt_on = 1; inst_ready = 1;
        restart();
        repeat (5) @(negedge clk);
        redirect = 1; redirect_pc = target;
        #4;
        chk_cnt++;
        if ({imem_rvalid, inst_valid, imem_req} !== 3'b110)
            $display("FAIL rr_precondition got rvalid=%b v=%b req=%b want 1 1 0", imem_rvalid, inst_valid, imem_req);
        else pass_cnt++;
        @(negedge clk); redirect = 0;
        #4;
        chk_cnt++;
        if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, target})
            $display("FAIL rr_flush got v=%b req=%b addr=%h want 0 1 %h", inst_valid, imem_req, imem_addr, target);
        else pass_cnt++;
        @(negedge clk); #4;
        chk_cnt++;
        if (inst_valid !== 1'b0) $display("FAIL rr_gap got v=%b want 0", inst_valid);
        else pass_cnt++;
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #4;
            chk_cnt++;
            if ({inst_valid, inst_pc} !== {1'b1, 16'(target + 16'(k))})
                $display("FAIL rr_stream got v=%b pc=%h want 1 %h", inst_valid, inst_pc, 16'(target + 16'(k)));
            else pass_cnt++;
        end
    endtask

    task test_reset_mid();
        lat = 1; gnt_rand = 0; gnt_on = 1; inst_ready = 0;
        restart();
        repeat (4) @(negedge clk);
        #4;
        chk_cnt++;
        if ({inst_valid, imem_rvalid, imem_req} !== 3'b110)
            $display("FAIL rm_precondition got v=%b rvalid=%b req=%b want 1 1 0", inst_valid, imem_rvalid, imem_req);
        else pass_cnt++;
        rst = 0;
        #1;
        chk_cnt++;
        if ({imem_req, inst_valid, imem_addr, inst, inst_pc} !== {1'b0, 1'b0, 16'h0, 16'h0, 16'h0})
            $display("FAIL rm_async got req=%b v=%b addr=%h inst=%h pc=%h want 0 0 0 0 0", imem_req, inst_valid, imem_addr, inst, inst_pc);
        else pass_cnt++;
        @(negedge clk); inst_ready = 1;
        @(negedge clk); rst = 1;
        #4;
        chk_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0}) $display("FAIL rm_restart got %b/%h want 1/0000", imem_req, imem_addr);
        else pass_cnt++;
        @(negedge clk); #4;
        chk_cnt++;
        if (inst_valid !== 1'b0) $display("FAIL rm_latency got v=%b want 0", inst_valid);
        else pass_cnt++;
        @(negedge clk); #4;
        chk_cnt++;
        if ({inst_valid, inst_pc} !== {1'b1, 16'h0}) $display("FAIL rm_first got v=%b pc=%h want 1 0000", inst_valid, inst_pc);
        else pass_cnt++;
    endtask

    task test_back_to_back();
        bit found;
        lat = 2; gnt_rand = 0; gnt_on = 1; inst_ready = 1;
        restart();
        repeat (4) @(negedge clk);
        redirect = 1; redirect_pc = 16'h0200;
        @(negedge clk); redirect_pc = 16'h0300;
        #4;
        chk_cnt++;
        if (imem_req !== 1'b0) $display("FAIL b2b_req got %b want 0", imem_req);
        else pass_cnt++;
        @(negedge clk); redirect = 0;
        #4;
        chk_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0300}) $display("FAIL b2b_addr got %b/%h want 1/0300", imem_req, imem_addr);
        else pass_cnt++;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk); #4;
            found = inst_valid;
        end
        chk_cnt++;
        if (!found || inst_pc !== 16'h0300) $display("FAIL b2b_first got found=%b pc=%h want 1 0300", found, inst_pc);
        else pass_cnt++;
    endtask

    task test_random();
        lat = $urandom_range(1, 3); gnt_rand = 1; inst_ready = 1;
        restart();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom);
            #4;
            chk_cnt++;
            if (pend.size() > 4) $display("FAIL rnd_credit got outstanding=%0d want <=4", pend.size());
            else pass_cnt++;
        end
        @(negedge clk);
        redirect = 0; gnt_rand = 0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_inflight();
        test_redirect_restart(16'h0100, 3);
        test_redirect_restart(16'hFFFE, 4);
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
